// File: rtl/preg_free_list_if.sv
// Rename/retire port bundle for the physical-register free list.
// master = rename + retire side, slave = the free-list manager.
interface preg_free_list_if #(
  parameter int unsigned NUM_PREGS = 128
);
  localparam int unsigned PREG_W = $clog2(NUM_PREGS);
  localparam int unsigned CNT_W  = $clog2(NUM_PREGS + 1);

  logic [1:0]             alloc_req;
  logic [1:0]             alloc_grant;
  logic [1:0][PREG_W-1:0] alloc_preg;
  logic                   stall;
  logic [2:0]             free_valid;
  logic [2:0][PREG_W-1:0] free_preg;
  logic [CNT_W-1:0]       free_count;
  logic                   overflow;
  logic                   double_free;

  modport master (
    output alloc_req, free_valid, free_preg,
    input  alloc_grant, alloc_preg, stall, free_count, overflow, double_free
  );

  modport slave (
    input  alloc_req, free_valid, free_preg,
    output alloc_grant, alloc_preg, stall, free_count, overflow, double_free
  );
endinterface

// File: rtl/preg_free_list.sv
// Circular-FIFO free list of physical register tags: two all-or-nothing allocs and
// three releases per cycle. Define FREELIST_DOUBLE_FREE_CHECK_EN to add the double-free bitmap.
module preg_free_list #(
  parameter int unsigned NUM_PREGS = 128,
  parameter int unsigned NUM_AREGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  preg_free_list_if.slave fl
);
  localparam int unsigned PREG_W   = $clog2(NUM_PREGS);
  localparam int unsigned CNT_W    = $clog2(NUM_PREGS + 1);
  localparam int unsigned INIT_CNT = NUM_PREGS - NUM_AREGS;

  logic [PREG_W-1:0] entries [NUM_PREGS];
  logic [PREG_W-1:0] head;
  logic [PREG_W-1:0] tail;
  logic [CNT_W-1:0]  count;
  logic              overflow_q;

  logic [1:0]             n_req;
  logic                   grant_ok;
  logic [1:0]             n_granted;
  logic [CNT_W-1:0]       room;
  logic [2:0]             cand;
  logic [2:0]             accept;
  logic [1:0]             n_acc;
  logic [1:0]             off;
  logic [2:0][PREG_W-1:0] wr_idx;
  logic                   cap_drop;

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  localparam logic [NUM_PREGS-1:0] IN_LIST_RST = {NUM_PREGS{1'b1}} << NUM_AREGS;
  logic [NUM_PREGS-1:0] in_list;
  logic                 double_free_q;
  logic                 dup_drop;
`endif

  // Allocation decision uses pre-free count only (no free-to-alloc bypass)
  always_comb begin
    n_req     = 2'(fl.alloc_req[0]) + 2'(fl.alloc_req[1]);
    grant_ok  = CNT_W'(n_req) <= count;
    n_granted = grant_ok ? n_req : 2'd0;
  end

  always_comb begin
    fl.alloc_grant = '0;
    fl.alloc_preg  = '0;
    fl.stall       = 1'b0;
    if (!i_rst) begin
      fl.alloc_grant[0] = fl.alloc_req[0] && grant_ok;
      fl.alloc_grant[1] = fl.alloc_req[1] && grant_ok;
      fl.alloc_preg[0]  = entries[head];
      fl.alloc_preg[1]  = fl.alloc_req[0] ? entries[head + PREG_W'(1)] : entries[head];
      fl.stall          = (n_req != 2'd0) && !grant_ok;
    end
  end

  // Filter frees (tag 0, double frees), then admit in index order up to remaining room
  always_comb begin
    room     = CNT_W'(NUM_PREGS) - (count - CNT_W'(n_granted));
    cand     = '0;
    accept   = '0;
    n_acc    = '0;
    off      = '0;
    wr_idx   = '0;
    cap_drop = 1'b0;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    dup_drop = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      if (fl.free_valid[i] && (fl.free_preg[i] != '0)) begin
        cand[i] = 1'b1;
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
        if (in_list[fl.free_preg[i]]) cand[i] = 1'b0;
        for (int j = 0; j < i; j++) begin
          if (cand[j] && (fl.free_preg[j] == fl.free_preg[i])) cand[i] = 1'b0;
        end
        if (!cand[i]) dup_drop = 1'b1;
`endif
      end
    end
    for (int i = 0; i < 3; i++) begin
      wr_idx[i] = tail + PREG_W'(off);
      if (cand[i]) begin
        if (CNT_W'(n_acc) < room) begin
          accept[i] = 1'b1;
          n_acc     = n_acc + 2'd1;
          off       = off + 2'd1;
        end else begin
          cap_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NUM_PREGS; k++) begin
        entries[k] <= (k < INIT_CNT) ? PREG_W'(k + NUM_AREGS) : '0;
      end
      head       <= '0;
      tail       <= PREG_W'(INIT_CNT);
      count      <= CNT_W'(INIT_CNT);
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept[i]) entries[wr_idx[i]] <= fl.free_preg[i];
      end
      head  <= head + PREG_W'(n_granted);
      tail  <= tail + PREG_W'(n_acc);
      count <= count - CNT_W'(n_granted) + CNT_W'(n_acc);
      if (cap_drop) overflow_q <= 1'b1;
    end
  end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
  // Membership bitmap: cleared on grant, set on accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_list       <= IN_LIST_RST;
      double_free_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fl.alloc_grant[i]) in_list[fl.alloc_preg[i]] <= 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (accept[i]) in_list[fl.free_preg[i]] <= 1'b1;
      end
      if (dup_drop) double_free_q <= 1'b1;
    end
  end

  assign fl.double_free = double_free_q;
`else
  assign fl.double_free = 1'b0;
`endif

  assign fl.free_count = count;
  assign fl.overflow   = overflow_q;
endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: reset, dual/single alloc, stall, frees,
// pointer wrap, capacity overflow and double-free handling.
module tb_preg_free_list;
  logic i_clk;
  logic i_rst;
  int   total;
  int   bad;
  logic [6:0] q[$];

  preg_free_list_if #(.NUM_PREGS(128)) fl();

  preg_free_list #(.NUM_PREGS(128), .NUM_AREGS(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .fl    (fl)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [2:0] fv,
                       input logic [6:0] t0, input logic [6:0] t1, input logic [6:0] t2);
    fl.alloc_req     = req;
    fl.free_valid    = fv;
    fl.free_preg[0]  = t0;
    fl.free_preg[1]  = t1;
    fl.free_preg[2]  = t2;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Reset with live traffic on the inputs; outputs must be forced quiet
  task automatic do_reset();
    i_rst = 1'b1;
    drive(2'b11, 3'b111, 7'd9, 7'd10, 7'd11);
    @(negedge i_clk);
    chk("rst_grant", 32'(fl.alloc_grant), 32'd0);
    chk("rst_stall", 32'(fl.stall), 32'd0);
    chk("rst_preg", 32'(fl.alloc_preg), 32'd0);
    cyc();
    i_rst = 1'b0;
    drive(2'b00, 3'b000, 7'd0, 7'd0, 7'd0);
    chk("rst_count", 32'(fl.free_count), 32'd96);
    chk("rst_ovf", 32'(fl.overflow), 32'd0);
    chk("rst_dfree", 32'(fl.double_free), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_rst = 1'b1;
    drive(2'b00, 3'b000, 7'd0, 7'd0, 7'd0);
    #1;
    do_reset();

    // Dual allocation after reset
    drive(2'b11, 3'b000, 7'd0, 7'd0, 7'd0);
    @(negedge i_clk);
    chk("dual_grant", 32'(fl.alloc_grant), 32'd3);
    chk("dual_preg0", 32'(fl.alloc_preg[0]), 32'd32);
    chk("dual_preg1", 32'(fl.alloc_preg[1]), 32'd33);
    chk("dual_stall", 32'(fl.stall), 32'd0);
    cyc();
    drive(2'b00, 3'b000, 7'd0, 7'd0, 7'd0);
    chk("dual_count", 32'(fl.free_count), 32'd94);

    // Slot 1 only takes the head tag
    do_reset();
    drive(2'b10, 3'b000, 7'd0, 7'd0, 7'd0);
    @(negedge i_clk);
    chk("s1_grant", 32'(fl.alloc_grant), 32'd2);
    chk("s1_preg1", 32'(fl.alloc_preg[1]), 32'd32);
    cyc();
    chk("s1_count", 32'(fl.free_count), 32'd95);

    // Drain to a single free tag
    do_reset();
    for (int k = 0; k < 47; k++) begin
      drive(2'b11, 3'b000, 7'd0, 7'd0, 7'd0);
      @(negedge i_clk);
      chk("drain_p0", 32'(fl.alloc_preg[0]), 32'(32 + 2 * k));
      chk("drain_p1", 32'(fl.alloc_preg[1]), 32'(33 + 2 * k));
      cyc();
    end
    chk("drain_count2", 32'(fl.free_count), 32'd2);
    drive(2'b01, 3'b000, 7'd0, 7'd0, 7'd0);
    @(negedge i_clk);
    chk("drain_last", 32'(fl.alloc_preg[0]), 32'd126);
    cyc();
    chk("drain_count1", 32'(fl.free_count), 32'd1);

    // One tag left, both request: stall; free of 40 lands anyway
    drive(2'b11, 3'b001, 7'd40, 7'd0, 7'd0);
    @(negedge i_clk);
    chk("short_grant", 32'(fl.alloc_grant), 32'd0);
    chk("short_stall", 32'(fl.stall), 32'd1);
    cyc();
    chk("short_count", 32'(fl.free_count), 32'd2);
    drive(2'b11, 3'b000, 7'd0, 7'd0, 7'd0);
    @(negedge i_clk);
    chk("retry_grant", 32'(fl.alloc_grant), 32'd3);
    chk("retry_p0", 32'(fl.alloc_preg[0]), 32'd127);
    chk("retry_p1", 32'(fl.alloc_preg[1]), 32'd40);
    cyc();
    chk("empty_count", 32'(fl.free_count), 32'd0);

    // Empty list stalls; tag 0 dropped, 50 and 51 accepted
    drive(2'b01, 3'b111, 7'd0, 7'd50, 7'd51);
    @(negedge i_clk);
    chk("empty_stall", 32'(fl.stall), 32'd1);
    chk("empty_grant", 32'(fl.alloc_grant), 32'd0);
    cyc();
    chk("x0_count", 32'(fl.free_count), 32'd2);
    drive(2'b01, 3'b000, 7'd0, 7'd0, 7'd0);
    @(negedge i_clk);
    chk("ret50", 32'(fl.alloc_preg[0]), 32'd50);
    cyc();
    drive(2'b10, 3'b000, 7'd0, 7'd0, 7'd0);
    @(negedge i_clk);
    chk("ret51_grant", 32'(fl.alloc_grant), 32'd2);
    chk("ret51", 32'(fl.alloc_preg[1]), 32'd51);
    cyc();
    chk("ret_count", 32'(fl.free_count), 32'd0);

    // Fill/drain rounds wrapping head and tail past 128
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 32; c++) begin
        logic [6:0] t [3];
        for (int j = 0; j < 3; j++) begin
          t[j] = (r == 0) ? 7'(1 + 3 * c + j) : 7'(127 - (3 * c + j));
          q.push_back(t[j]);
        end
        drive(2'b00, 3'b111, t[0], t[1], t[2]);
        cyc();
      end
      chk("wrap_fill", 32'(fl.free_count), 32'd96);
      for (int c = 0; c < 48; c++) begin
        logic [6:0] e0;
        logic [6:0] e1;
        e0 = q.pop_front();
        e1 = q.pop_front();
        drive(2'b11, 3'b000, 7'd0, 7'd0, 7'd0);
        @(negedge i_clk);
        chk("wrap_p0", 32'(fl.alloc_preg[0]), 32'(e0));
        chk("wrap_p1", 32'(fl.alloc_preg[1]), 32'(e1));
        cyc();
      end
      chk("wrap_drain", 32'(fl.free_count), 32'd0);
    end
    drive(2'b00, 3'b000, 7'd0, 7'd0, 7'd0);
    chk("wrap_ovf", 32'(fl.overflow), 32'd0);

`ifndef FREELIST_DOUBLE_FREE_CHECK_EN
    // Overfill: 129 offered, only 128 fit
    for (int c = 0; c < 43; c++) begin
      drive(2'b00, 3'b111, 7'd5, 7'd6, 7'd7);
      cyc();
    end
    drive(2'b00, 3'b000, 7'd0, 7'd0, 7'd0);
    chk("full_count", 32'(fl.free_count), 32'd128);
    chk("full_ovf", 32'(fl.overflow), 32'd1);
`endif

    do_reset();
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    drive(2'b00, 3'b001, 7'd60, 7'd0, 7'd0);
    cyc();
    chk("df60_count", 32'(fl.free_count), 32'd96);
    chk("df60_flag", 32'(fl.double_free), 32'd1);
    drive(2'b11, 3'b000, 7'd0, 7'd0, 7'd0);
    cyc();
    drive(2'b00, 3'b011, 7'd32, 7'd32, 7'd0);
    cyc();
    chk("dfsame_count", 32'(fl.free_count), 32'd95);
`else
    drive(2'b00, 3'b001, 7'd60, 7'd0, 7'd0);
    cyc();
    chk("nodf_count", 32'(fl.free_count), 32'd97);
    chk("nodf_flag", 32'(fl.double_free), 32'd0);
`endif

    // Reset mid-stream restores reset state and clears flags
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list manager for the rename stage. It holds unallocated physical register tags in a circular FIFO and hands out up to two destination tags per cycle to the two rename slots, all-or-nothing. It also accepts up to three released tags per cycle from the retire path. It replaces the bitmap scan inside rename with a sequenced, stall-aware allocator, and it arbitrates the physical register pool between rename (consumer) and retire (producer).

## Interface
Parameters:
- `NUM_PREGS`, 128: physical register count; FIFO depth; tag width is `$clog2(NUM_PREGS)` = 7 (`p_reg`).
- `NUM_AREGS`, 32: architectural registers; tags 0..`NUM_AREGS`-1 are mapped at reset and never start in the list.

Ports (clock and reset first):
- `i_clk`, in, 1: the single clock; all state updates on its rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_alloc_req[0:1]`, in, 1 each: rename slot *i* needs a destination tag this cycle.
- `o_alloc_grant[0:1]`, out, 1 each: slot *i* receives `o_alloc_preg[i]` this cycle.
- `o_alloc_preg[0:1]`, out, `p_reg`: allocated tag; valid only when the matching grant is high.
- `o_stall`, out, 1: at least one request was not granted; rename must hold both slots.
- `i_free_valid[0:2]`, in, 1 each: retire releases `i_free_preg[i]` (the OldPRegAddrDst).
- `i_free_preg[0:2]`, in, `p_reg`: tag being released.
- `o_free_count`, out, 8: number of tags currently in the list (0..128).
- `o_overflow`, out, 1: sticky; set when a free was dropped because the list was full.
- `o_double_free`, out, 1: sticky double-free flag; tied 0 when the checker is compiled out.

## Operation
- State: `entries[0:NUM_PREGS-1]`, 7-bit `head`, 7-bit `tail`, 8-bit `count`, sticky flags.
- Reset state:
  - `entries[k] = k + NUM_AREGS` for k < 96.
  - `head = 0`, `tail = 96`, `count = 96`.
  - Flags cleared.
- Request count: `n_req = i_alloc_req[0] + i_alloc_req[1]`.
- Grant rule (all-or-nothing):
  - If `n_req <= count`, every requesting slot is granted. Otherwise no slot is granted and `o_stall = 1`.
  - `o_stall = (n_req != 0) && !grant`. When `n_req == 0`, `o_stall = 0`.
- Tag order:
  - If slot 0 is granted, it takes `entries[head]`.
  - Slot 1 takes `entries[head+1]` if slot 0 also requested, else `entries[head]`.
  - On grant, `head` advances by `n_req` (mod 128).
- Frees:
  - Valid frees are processed in index order 0, 1, 2.
  - Tag 0 is discarded silently (the x0 mapping is never recycled).
  - Each accepted tag is written at `tail`, `tail+1`, ...; `tail` advances by the accepted count.
- Capacity:
  - Accepted frees are limited so that `count - n_granted + n_accepted <= NUM_PREGS`.
  - Excess frees are dropped from the highest index first, and `o_overflow` is set.
- Count update: `count_next = count - n_granted + n_accepted`; 8-bit with no wrap, since the capacity limit keeps it ≤ 128.
- Pointers: all pointer arithmetic wraps modulo 128.

## Timing
- Allocation has zero latency: grant and tag are combinational from registered state plus `i_alloc_req`. `head` updates on the next edge.
- Frees take effect one cycle later: a tag freed in cycle N becomes allocatable no earlier than cycle N+1. There is no free-to-alloc bypass, so `count` at cycle N excludes cycle-N frees.
- Simultaneous alloc and free in one cycle: both apply. The alloc decision uses the pre-free `count`.
- Empty (`count = 0`): any request stalls; frees in that cycle still land.
- Exactly 1 free tag and both slots requesting: stall, no grant, `head` unchanged.
- While `i_rst = 1`:
  - Outputs are forced: grants 0, `o_alloc_preg` 0, `o_stall` 0.
  - Requests and frees are ignored.
  - Reset state is loaded at that edge, regardless of in-flight activity.
- `o_free_count` and the flags are registered and reflect state after the last edge.

## Configuration
- Macro: `FREELIST_DOUBLE_FREE_CHECK_EN`.
- When defined:
  - A 128-bit `in_list` bitmap is maintained. Set on accept, cleared on grant; reset value is bits 32..127 set.
  - A free whose tag is already in the list is dropped and sets `o_double_free`. This covers a tag matching an earlier free in the same cycle.
  - Dropped double frees do not count toward `n_accepted`.
- When undefined:
  - No bitmap is present; every non-zero valid free is accepted (subject to capacity).
  - `o_double_free` is constant 0.

## Test plan
- Reset then idle → `o_free_count = 96`. With `i_alloc_req = {1,1}`, grants `{1,1}`, tags 32 and 33; next cycle count = 94.
- Request only slot 1 after reset → `o_alloc_grant = {0,1}`, `o_alloc_preg[1] = 32`, count 95.
- Drain to count = 1, then request both → no grants, `o_stall = 1`, head unchanged. Free tag 40 in that same cycle → next cycle count = 2, and a dual request grants both.
- Free `{valid=1,1,1; tags=0,50,51}` → tag 0 discarded, count +2; subsequent allocations return 50 then 51 after the existing entries wrap around.
- Allocate 96 then free 96 in a loop exceeding 128 pointer steps → pointers wrap, tags return in FIFO order, `o_overflow` stays 0.
- With `FREELIST_DOUBLE_FREE_CHECK_EN`: free tag 60 (already in list after reset) → dropped, `o_double_free = 1`, count unchanged. Assert `i_rst` mid-stream → flag clears and count = 96 next cycle.
